reg_file_scoreboard: RTL and testbench

REG_FILE_SCOREBOARD -- requirements
Module: reg_file_scoreboard

---
 rtl/reg_file_scoreboard_pkg.sv | 8 +
 rtl/reg_file_sb_pending.sv | 74 +++++++
 rtl/reg_file_scoreboard.sv | 80 ++++++++
 tb/tb_reg_file_scoreboard.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_scoreboard_pkg.sv
// Shared constants for the register file scoreboard slice.
// Optional same-cycle write bypass is enabled by REG_FILE_SCOREBOARD_BYPASS_EN.
package reg_file_scoreboard_pkg;
   localparam int DEF_DATA_W    = 32;
   localparam int DEF_ADDR_W    = 5;
   localparam int DEF_NUM_RD    = 2;
   localparam int REG_ZERO_ADDR = 0;
endpackage

// File: rtl/reg_file_sb_pending.sv
// Pending-bit scoreboard: one bit per register, registered population count
// and a sticky flag for issues that land on an already-pending register.
module reg_file_sb_pending
   import reg_file_scoreboard_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   wr_en_i,
   input  logic [ADDR_W-1:0]      wr_addr_i,
   input  logic                   iss_en_i,
   input  logic [ADDR_W-1:0]      iss_addr_i,
   output logic [(2**ADDR_W)-1:0] pend_o,
   output logic [ADDR_W:0]        pend_cnt_o,
   output logic                   iss_conflict_o
);
   localparam int DEPTH = 2**ADDR_W;

   logic [DEPTH-1:0] pend_r;
   logic [DEPTH-1:0] pend_nxt_s;
   logic [ADDR_W:0]  cnt_r;
   logic             conflict_r;
   logic             set_s;
   logic             clr_s;
   logic             same_s;
   logic             inc_s;
   logic             dec_s;
   logic             conflict_s;

   // Next-state of the pending vector; an issue wins over a same-address writeback.
   always_comb begin
      set_s      = iss_en_i && (iss_addr_i != ADDR_W'(REG_ZERO_ADDR));
      clr_s      = wr_en_i  && (wr_addr_i  != ADDR_W'(REG_ZERO_ADDR));
      same_s     = set_s && clr_s && (iss_addr_i == wr_addr_i);
      inc_s      = set_s && !pend_r[iss_addr_i];
      dec_s      = clr_s && pend_r[wr_addr_i] && !same_s;
      conflict_s = set_s && pend_r[iss_addr_i] && !same_s;
      pend_nxt_s = pend_r;
      if (clr_s) begin
         pend_nxt_s[wr_addr_i] = 1'b0;
      end else begin
         pend_nxt_s = pend_nxt_s;
      end
      if (set_s) begin
         pend_nxt_s[iss_addr_i] = 1'b1;
      end else begin
         pend_nxt_s = pend_nxt_s;
      end
   end

   // Pending bits, counter and sticky conflict flag.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         pend_r     <= '0;
         cnt_r      <= '0;
         conflict_r <= 1'b0;
      end else begin
         pend_r <= pend_nxt_s;
         case ({inc_s, dec_s})
            2'b10:   cnt_r <= cnt_r + (ADDR_W+1)'(1);
            2'b01:   cnt_r <= cnt_r - (ADDR_W+1)'(1);
            default: cnt_r <= cnt_r;
         endcase
         if (conflict_s) begin
            conflict_r <= 1'b1;
         end
      end
   end

   assign pend_o         = pend_r;
   assign pend_cnt_o     = cnt_r;
   assign iss_conflict_o = conflict_r;
endmodule

// File: rtl/reg_file_scoreboard.sv
// Multi-read-port register file with issue/writeback scoreboard.
// Define REG_FILE_SCOREBOARD_BYPASS_EN to forward writeback data to reads in the same cycle.
module reg_file_scoreboard
   import reg_file_scoreboard_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NUM_RD = DEF_NUM_RD
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
   output logic [NUM_RD*DATA_W-1:0] rd_data_o,
   output logic [NUM_RD-1:0]        rd_busy_o,
   input  logic                     wr_en_i,
   input  logic [ADDR_W-1:0]        wr_addr_i,
   input  logic [DATA_W-1:0]        wr_data_i,
   input  logic                     iss_en_i,
   input  logic [ADDR_W-1:0]        iss_addr_i,
   output logic                     iss_conflict_o,
   output logic [ADDR_W:0]          pend_cnt_o
);
   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0]        mem_r [DEPTH];
   logic [DEPTH-1:0]         pend_s;
   logic [NUM_RD*DATA_W-1:0] rd_data_s;
   logic [NUM_RD-1:0]        rd_busy_s;

   reg_file_sb_pending #(.ADDR_W(ADDR_W)) u_pending (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .wr_en_i        (wr_en_i),
      .wr_addr_i      (wr_addr_i),
      .iss_en_i       (iss_en_i),
      .iss_addr_i     (iss_addr_i),
      .pend_o         (pend_s),
      .pend_cnt_o     (pend_cnt_o),
      .iss_conflict_o (iss_conflict_o)
   );

   // Storage array; register zero is never written so it stays at reset value.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (wr_en_i && (wr_addr_i != ADDR_W'(REG_ZERO_ADDR))) begin
         mem_r[wr_addr_i] <= wr_data_i;
      end
   end

   // Read muxes and busy lookup per read port.
   always_comb begin
      rd_data_s = '0;
      rd_busy_s = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         if (rd_addr_i[k*ADDR_W +: ADDR_W] == ADDR_W'(REG_ZERO_ADDR)) begin
            rd_data_s[k*DATA_W +: DATA_W] = '0;
            rd_busy_s[k]                  = 1'b0;
         end else begin
            rd_data_s[k*DATA_W +: DATA_W] = mem_r[rd_addr_i[k*ADDR_W +: ADDR_W]];
            rd_busy_s[k]                  = pend_s[rd_addr_i[k*ADDR_W +: ADDR_W]];
`ifdef REG_FILE_SCOREBOARD_BYPASS_EN
            if (wr_en_i && (wr_addr_i == rd_addr_i[k*ADDR_W +: ADDR_W])) begin
               rd_data_s[k*DATA_W +: DATA_W] = wr_data_i;
               rd_busy_s[k] = iss_en_i && (iss_addr_i == rd_addr_i[k*ADDR_W +: ADDR_W]);
            end else begin
               rd_busy_s[k] = rd_busy_s[k];
            end
`else
            rd_busy_s[k] = rd_busy_s[k];
`endif
         end
      end
   end

   assign rd_data_o = rd_data_s;
   assign rd_busy_o = rd_busy_s;
endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed self-checking bench for reg_file_scoreboard (default parameters).
module tb_reg_file_scoreboard;
   logic        clk;
   logic        rst_i;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic [1:0]  rd_busy;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        iss_en;
   logic [4:0]  iss_addr;
   logic        conflict;
   logic [5:0]  pend_cnt;
   int          checks;
   int          passes;

   reg_file_scoreboard dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .rd_addr_i      (rd_addr),
      .rd_data_o      (rd_data),
      .rd_busy_o      (rd_busy),
      .wr_en_i        (wr_en),
      .wr_addr_i      (wr_addr),
      .wr_data_i      (wr_data),
      .iss_en_i       (iss_en),
      .iss_addr_i     (iss_addr),
      .iss_conflict_o (conflict),
      .pend_cnt_o     (pend_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_i = 1'b0; wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
      iss_en = 1'b0; iss_addr = 5'd0; rd_addr = 10'd0;
      step(); step();
      #2 rst_i = 1'b1;
      step();
      checks++;
      if (pend_cnt !== 6'd0 || conflict !== 1'b0)
         $display("FAIL reset_state: cnt=%0d conflict=%b, want 0/0", pend_cnt, conflict);
      else passes++;
      for (int a = 0; a < 32; a++) begin
         rd_addr = {5'(31 - a), 5'(a)};
         #1;
         checks++;
         if (rd_data !== 64'd0 || rd_busy !== 2'b00)
            $display("FAIL reset_read a=%0d: data=%h busy=%b, want 0/00", a, rd_data, rd_busy);
         else passes++;
      end
   endtask

   task automatic test_write_read();
      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF;
      rd_addr = {5'd0, 5'd7};
      step();
      wr_en = 1'b0;
      #1;
      checks++;
      if (rd_data[31:0] !== 32'hDEADBEEF)
         $display("FAIL write_r7: got %h, want deadbeef", rd_data[31:0]);
      else passes++;
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h00001234;
      step();
      wr_en = 1'b0;
      #1;
      checks++;
      if (rd_data[63:32] !== 32'd0 || rd_busy !== 2'b00)
         $display("FAIL write_r0: got %h busy=%b, want 0/00", rd_data[63:32], rd_busy);
      else passes++;
   endtask

   task automatic test_issue_wb();
      iss_en = 1'b1; iss_addr = 5'd3;
      step();
      checks++;
      if (pend_cnt !== 6'd1) $display("FAIL issue_r3_cnt: got %0d, want 1", pend_cnt);
      else passes++;
      iss_addr = 5'd4;
      step();
      iss_en = 1'b0;
      rd_addr = {5'd4, 5'd3};
      #1;
      checks++;
      if (pend_cnt !== 6'd2 || rd_busy !== 2'b11)
         $display("FAIL issue_r4: cnt=%0d busy=%b, want 2/11", pend_cnt, rd_busy);
      else passes++;
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h00000033;
      step();
      wr_en = 1'b0;
      #1;
      checks++;
      if (pend_cnt !== 6'd1 || rd_busy !== 2'b10 || rd_data[31:0] !== 32'h33 || conflict !== 1'b0)
         $display("FAIL wb_r3: cnt=%0d busy=%b data=%h conflict=%b, want 1/10/33/0",
                  pend_cnt, rd_busy, rd_data[31:0], conflict);
      else passes++;
   endtask

   task automatic test_same_edge_conflict();
      iss_en = 1'b1; iss_addr = 5'd5;
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h00000055;
      step();
      wr_en = 1'b0; iss_en = 1'b0;
      rd_addr = {5'd4, 5'd5};
      #1;
      checks++;
      if (pend_cnt !== 6'd2 || rd_busy !== 2'b11 || rd_data[31:0] !== 32'h55 || conflict !== 1'b0)
         $display("FAIL same_edge_r5: cnt=%0d busy=%b data=%h conflict=%b, want 2/11/55/0",
                  pend_cnt, rd_busy, rd_data[31:0], conflict);
      else passes++;
      iss_en = 1'b1; iss_addr = 5'd5;
      step();
      iss_en = 1'b0;
      checks++;
      if (conflict !== 1'b1 || pend_cnt !== 6'd2)
         $display("FAIL conflict_set: conflict=%b cnt=%0d, want 1/2", conflict, pend_cnt);
      else passes++;
      step(); step();
      checks++;
      if (conflict !== 1'b1) $display("FAIL conflict_sticky: got %b, want 1", conflict);
      else passes++;
   endtask

   task automatic test_bypass();
      wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A5A5A5;
      rd_addr = {5'd0, 5'd9};
      #1;
      checks++;
`ifdef REG_FILE_SCOREBOARD_BYPASS_EN
      if (rd_data[31:0] !== 32'hA5A5A5A5 || rd_busy[0] !== 1'b0)
         $display("FAIL bypass_same: data=%h busy=%b, want a5a5a5a5/0", rd_data[31:0], rd_busy[0]);
      else passes++;
`else
      if (rd_data[31:0] !== 32'd0)
         $display("FAIL nobypass_same: data=%h, want 0", rd_data[31:0]);
      else passes++;
`endif
      step();
      wr_en = 1'b0;
      #1;
      checks++;
      if (rd_data[31:0] !== 32'hA5A5A5A5)
         $display("FAIL bypass_next: data=%h, want a5a5a5a5", rd_data[31:0]);
      else passes++;
   endtask

   task automatic test_async_reset();
      iss_en = 1'b1; iss_addr = 5'd2;
      step();
      iss_en = 1'b0;
      checks++;
      if (pend_cnt !== 6'd3) $display("FAIL pre_reset_cnt: got %0d, want 3", pend_cnt);
      else passes++;
      wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h0000FFFF;
      rd_addr = {5'd7, 5'd2};
      #2 rst_i = 1'b0;
      #1 wr_en = 1'b0;
      #1;
      checks++;
      if (pend_cnt !== 6'd0 || conflict !== 1'b0 || rd_busy !== 2'b00 || rd_data !== 64'd0)
         $display("FAIL async_clear: cnt=%0d conflict=%b busy=%b data=%h, want all 0",
                  pend_cnt, conflict, rd_busy, rd_data);
      else passes++;
      wr_en = 1'b1; iss_en = 1'b1; iss_addr = 5'd2;
      step();
      wr_en = 1'b0; iss_en = 1'b0;
      #2 rst_i = 1'b1;
      #1;
      checks++;
      if (rd_data !== 64'd0 || pend_cnt !== 6'd0 || rd_busy !== 2'b00)
         $display("FAIL after_release: data=%h cnt=%0d busy=%b, want 0/0/00", rd_data, pend_cnt, rd_busy);
      else passes++;
      iss_en = 1'b1; iss_addr = 5'd6;
      step();
      iss_en = 1'b0;
      checks++;
      if (pend_cnt !== 6'd1) $display("FAIL first_update: cnt=%0d, want 1", pend_cnt);
      else passes++;
   endtask

   initial begin
      checks = 0;
      passes = 0;
      test_reset();
      test_write_read();
      test_issue_wb();
      test_same_edge_conflict();
      test_bypass();
      test_async_reset();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
